// File: rtl/qbert_test2_cpu_debug_sysclk_bridge.sv
// JTAG virtual-IR/DR to system-clock bridge: synchronises tck-domain update levels,
// captures IR and DR contents and issues one-hot action strobes with optional ack handshake.
module qbert_test2_cpu_debug_sysclk_bridge #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = 34,
    parameter int ACK_EN      = 1,
    localparam int NCH        = 2 ** IR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vs_uir,
    input  logic              vs_udr,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [DATA_W-1:0] sr,
    input  logic              act_ack,
    input  logic              clear_overrun,
    output logic [DATA_W-1:0] jdo,
    output logic [IR_W-1:0]   ir_q,
    output logic              ir_update,
    output logic [NCH-1:0]    take_action,
    output logic [NCH-1:0]    take_no_action,
    output logic              pending,
    output logic              overrun
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_uir_sync;
    logic [SYNC_STAGES-1:0] r_udr_sync;
    logic                   r_uir_dly;
    logic                   r_udr_dly;
    logic                   w_uir_rise;
    logic                   w_udr_rise;
    logic                   w_accept;
    logic                   w_overrun_set;
    logic [NCH-1:0]         w_sel;

    logic [DATA_W-1:0]      r_jdo;
    logic [IR_W-1:0]        r_ir_q;
    logic                   r_ir_update;
    logic [NCH-1:0]         r_take_action;
    logic [NCH-1:0]         r_take_no_action;
    logic                   r_overrun;

    // Bit 0 is the first synchroniser stage; the delay flop follows the last stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_uir_sync <= '0;
            r_udr_sync <= '0;
            r_uir_dly  <= 1'b0;
            r_udr_dly  <= 1'b0;
        end else begin
            r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
            r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
            r_uir_dly  <= r_uir_sync[SYNC_STAGES-1];
            r_udr_dly  <= r_udr_sync[SYNC_STAGES-1];
        end
    end

    assign w_uir_rise = r_uir_sync[SYNC_STAGES-1] & ~r_uir_dly;
    assign w_udr_rise = r_udr_sync[SYNC_STAGES-1] & ~r_udr_dly;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_sel
            assign w_sel[gi] = (r_ir_q == IR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_overrun_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_udr_rise) begin
                    w_state_next = S_STROBE;
                    w_accept     = 1'b1;
                end
            end
            S_STROBE: begin
                w_state_next = (ACK_EN != 0) ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                // A new command outranks the ack; it only counts as lost if unacked.
                if (w_udr_rise) begin
                    w_state_next  = S_STROBE;
                    w_accept      = 1'b1;
                    w_overrun_set = ~act_ack;
                end else if (act_ack) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Strobe index uses the pre-update ir_q when IR and DR rises coincide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_jdo            <= '0;
            r_ir_q           <= '0;
            r_ir_update      <= 1'b0;
            r_take_action    <= '0;
            r_take_no_action <= '0;
            r_overrun        <= 1'b0;
        end else begin
            r_ir_update      <= w_uir_rise;
            r_take_action    <= (w_accept && sr[ACT_BIT])  ? w_sel : '0;
            r_take_no_action <= (w_accept && !sr[ACT_BIT]) ? w_sel : '0;
            r_overrun        <= w_overrun_set | (r_overrun & ~clear_overrun);
            if (w_uir_rise) begin
                r_ir_q <= ir_in;
            end
            if (w_accept) begin
                r_jdo <= sr;
            end
        end
    end

    assign jdo            = r_jdo;
    assign ir_q           = r_ir_q;
    assign ir_update      = r_ir_update;
    assign take_action    = r_take_action;
    assign take_no_action = r_take_no_action;
    assign overrun        = r_overrun;
    assign pending        = (r_state == S_WAIT) || ((r_state == S_STROBE) && (ACK_EN != 0));

endmodule

// File: tb/tb_qbert_test2_cpu_debug_sysclk_bridge.sv
// Bench for the JTAG sysclk bridge: three instances (defaults, no-ack, wide/3-stage) driven
// by shared stimulus and checked every cycle against an event-level model plus directed vectors.
module tb_qbert_test2_cpu_debug_sysclk_bridge;

    localparam int SS_P  [3] = '{2, 2, 3};
    localparam int DW_P  [3] = '{38, 38, 44};
    localparam int IRW_P [3] = '{2, 2, 3};
    localparam int ACK_P [3] = '{1, 0, 1};

    typedef struct packed {
        logic [43:0] jdo;
        logic [2:0]  irq;
        logic        iru;
        logic [7:0]  ta;
        logic [7:0]  tn;
        logic        pend;
        logic        ov;
    } out_t;

    typedef struct packed {
        logic [7:0] hu;
        logic [7:0] hd;
        out_t       o;
        logic       strobing;
    } mdl_t;

    typedef struct packed {
        logic [2:0]  ir;
        logic [43:0] sr;
        logic [3:0]  exp_ta;
        logic [3:0]  exp_tn;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vs_uir, vs_udr, act_ack, clear_overrun;
    logic [2:0]  ir_in;
    logic [43:0] sr;

    logic [37:0] a_jdo, b_jdo;
    logic [43:0] c_jdo;
    logic [1:0]  a_irq, b_irq;
    logic [2:0]  c_irq;
    logic        a_iru, b_iru, c_iru;
    logic [3:0]  a_ta, a_tn, b_ta, b_tn;
    logic [7:0]  c_ta, c_tn;
    logic        a_pend, b_pend, c_pend, a_ov, b_ov, c_ov;

    int   vectors = 0;
    int   miscompares = 0;
    int   strb_a, strb_b, strb_c;
    logic b_flag;
    mdl_t m [3];

    always #5 clk = ~clk;

    qbert_test2_cpu_debug_sysclk_bridge u_dut_a (
        .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
        .ir_in(ir_in[1:0]), .sr(sr[37:0]), .act_ack(act_ack), .clear_overrun(clear_overrun),
        .jdo(a_jdo), .ir_q(a_irq), .ir_update(a_iru), .take_action(a_ta),
        .take_no_action(a_tn), .pending(a_pend), .overrun(a_ov)
    );

    qbert_test2_cpu_debug_sysclk_bridge #(.ACK_EN(0)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
        .ir_in(ir_in[1:0]), .sr(sr[37:0]), .act_ack(act_ack), .clear_overrun(clear_overrun),
        .jdo(b_jdo), .ir_q(b_irq), .ir_update(b_iru), .take_action(b_ta),
        .take_no_action(b_tn), .pending(b_pend), .overrun(b_ov)
    );

    qbert_test2_cpu_debug_sysclk_bridge #(.DATA_W(44), .IR_W(3), .SYNC_STAGES(3)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
        .ir_in(ir_in), .sr(sr), .act_ack(act_ack), .clear_overrun(clear_overrun),
        .jdo(c_jdo), .ir_q(c_irq), .ir_update(c_iru), .take_action(c_ta),
        .take_no_action(c_tn), .pending(c_pend), .overrun(c_ov)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic out_t get_out(input int i);
        out_t o;
        o = '0;
        case (i)
            0: begin
                o.jdo = 44'(a_jdo); o.irq = 3'(a_irq); o.iru = a_iru;
                o.ta = 8'(a_ta); o.tn = 8'(a_tn); o.pend = a_pend; o.ov = a_ov;
            end
            1: begin
                o.jdo = 44'(b_jdo); o.irq = 3'(b_irq); o.iru = b_iru;
                o.ta = 8'(b_ta); o.tn = 8'(b_tn); o.pend = b_pend; o.ov = b_ov;
            end
            default: begin
                o.jdo = c_jdo; o.irq = c_irq; o.iru = c_iru;
                o.ta = c_ta; o.tn = c_tn; o.pend = c_pend; o.ov = c_ov;
            end
        endcase
        return o;
    endfunction

    // Command-level model: a command is a level that was low then high SS samples ago;
    // pending lasts from a command until an ack that arrives after the strobe cycle.
    function automatic mdl_t step(input mdl_t cur, input int i);
        mdl_t        n;
        logic        cmd, ur, in_wait;
        logic [43:0] dmask;
        logic [2:0]  imask;
        n       = cur;
        n.hu    = {cur.hu[6:0], vs_uir};
        n.hd    = {cur.hd[6:0], vs_udr};
        ur      = n.hu[SS_P[i]] & ~n.hu[SS_P[i]+1];
        cmd     = n.hd[SS_P[i]] & ~n.hd[SS_P[i]+1];
        dmask   = (44'd1 << DW_P[i]) - 44'd1;
        imask   = (3'd1 << IRW_P[i]) - 3'd1;
        in_wait = cur.o.pend && !cur.strobing;
        n.o.iru = ur;
        if (ur) n.o.irq = ir_in & imask;
        n.o.ta = '0;
        n.o.tn = '0;
        if (cmd) begin
            n.o.jdo = sr & dmask;
            if (sr[34]) n.o.ta = 8'd1 << cur.o.irq;
            else        n.o.tn = 8'd1 << cur.o.irq;
        end
        n.o.ov     = (cmd && in_wait && !act_ack) || (cur.o.ov && !clear_overrun);
        n.strobing = cmd;
        if (cmd) n.o.pend = (ACK_P[i] != 0);
        else if (in_wait && act_ack) n.o.pend = 1'b0;
        return n;
    endfunction

    task automatic check_all();
        out_t o;
        for (int i = 0; i < 3; i++) begin
            o = get_out(i);
            chk($sformatf("u%0d.jdo", i), 64'(o.jdo), 64'(m[i].o.jdo));
            chk($sformatf("u%0d.ir_q", i), 64'(o.irq), 64'(m[i].o.irq));
            chk($sformatf("u%0d.ir_update", i), 64'(o.iru), 64'(m[i].o.iru));
            chk($sformatf("u%0d.take_action", i), 64'(o.ta), 64'(m[i].o.ta));
            chk($sformatf("u%0d.take_no_action", i), 64'(o.tn), 64'(m[i].o.tn));
            chk($sformatf("u%0d.pending", i), 64'(o.pend), 64'(m[i].o.pend));
            chk($sformatf("u%0d.overrun", i), 64'(o.ov), 64'(m[i].o.ov));
            chk($sformatf("u%0d.onehot", i), 64'($countones(o.ta | o.tn) <= 1), 64'd1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (reset_n) m[i] = step(m[i], i);
            else         m[i] = '0;
        end
        @(negedge clk);
        check_all();
        if ((a_ta | a_tn) != 4'd0) strb_a++;
        if ((b_ta | b_tn) != 4'd0) strb_b++;
        if ((c_ta | c_tn) != 8'd0) strb_c++;
        b_flag = b_flag | b_pend | b_ov;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) m[i] = '0;
        check_all();
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic udr_pulse(input logic [43:0] v);
        sr = v;
        vs_udr = 1'b1;
        tick();
        vs_udr = 1'b0;
        repeat (5) tick();
    endtask

    vec_t        tbl [4];
    int          n;
    logic [63:0] r64;

    initial begin
        tbl[0] = '{3'd2, 44'h04_0000_0001, 4'b0100, 4'b0000};
        tbl[1] = '{3'd1, 44'h00_0000_0005, 4'b0000, 4'b0010};
        tbl[2] = '{3'd3, 44'h3F_FFFF_FFFF, 4'b1000, 4'b0000};
        tbl[3] = '{3'd0, 44'h3B_FFFF_FFFF, 4'b0000, 4'b0001};

        reset_n = 1'b1; vs_uir = 1'b0; vs_udr = 1'b0; act_ack = 1'b0;
        clear_overrun = 1'b0; ir_in = '0; sr = '0;
        strb_a = 0; strb_b = 0; strb_c = 0; b_flag = 1'b0;
        for (int i = 0; i < 3; i++) m[i] = '0;
        #1 reset_n = 1'b0;
        repeat (2) tick();
        chk("reset jdo", 64'(a_jdo), 64'd0);
        chk("reset pending", 64'(a_pend), 64'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Directed commands: IR load, DR capture, strobe latency and ack handshake.
        for (int v = 0; v < 4; v++) begin
            ir_in = tbl[v].ir;
            vs_uir = 1'b1;
            tick();
            vs_uir = 1'b0;
            repeat (4) tick();
            chk("tbl ir_q", 64'(a_irq), 64'(tbl[v].ir[1:0]));
            sr = tbl[v].sr;
            vs_udr = 1'b1;
            n = 0;
            while (n < 10 && (a_ta | a_tn) == 4'd0) begin
                tick();
                n++;
            end
            chk("tbl latency", 64'(n), 64'd3);
            chk("tbl take_action", 64'(a_ta), 64'(tbl[v].exp_ta));
            chk("tbl take_no_action", 64'(a_tn), 64'(tbl[v].exp_tn));
            chk("tbl jdo", 64'(a_jdo), 64'(tbl[v].sr[37:0]));
            tick();
            chk("tbl strobe width", 64'(a_ta | a_tn), 64'd0);
            chk("tbl pending", 64'(a_pend), 64'd1);
            vs_udr = 1'b0;
            repeat (3) tick();
            chk("tbl pending held", 64'(a_pend), 64'd1);
            act_ack = 1'b1;
            tick();
            act_ack = 1'b0;
            tick();
            chk("tbl pending acked", 64'(a_pend), 64'd0);
        end

        // Overrun: unacked second command, clear, then clear colliding with a third.
        strb_a = 0;
        udr_pulse(44'h01_2345_6789);
        chk("ovr first pending", 64'(a_pend), 64'd1);
        chk("ovr first overrun", 64'(a_ov), 64'd0);
        udr_pulse(44'h02_AAAA_5555);
        chk("ovr strobes", 64'(strb_a), 64'd2);
        chk("ovr jdo newest", 64'(a_jdo), 64'h02_AAAA_5555);
        chk("ovr set", 64'(a_ov), 64'd1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        tick();
        chk("ovr cleared", 64'(a_ov), 64'd0);
        sr = 44'h03_0F0F_0F0F;
        vs_udr = 1'b1;
        tick();
        vs_udr = 1'b0;
        tick();
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("ovr set beats clear", 64'(a_ov), 64'd1);
        chk("ovr third strobe", 64'(strb_a), 64'd3);
        repeat (3) tick();
        act_ack = 1'b1; clear_overrun = 1'b1;
        tick();
        act_ack = 1'b0; clear_overrun = 1'b0;
        tick();
        chk("ovr final overrun", 64'(a_ov), 64'd0);
        chk("ovr final pending", 64'(a_pend), 64'd0);

        // Fire-and-forget: back-to-back commands at the maximum rise rate.
        strb_b = 0; b_flag = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sr = 44'(k + 1);
            vs_udr = 1'b1;
            tick();
            vs_udr = 1'b0;
            tick();
        end
        repeat (4) tick();
        chk("noack strobes", 64'(strb_b), 64'd3);
        chk("noack pending/overrun seen", 64'(b_flag), 64'd0);
        act_ack = 1'b1;
        tick();
        act_ack = 1'b0;
        tick();

        // Coincident IR/DR rises index the old IR; then reset during WAIT.
        chk("coinc ir_q before", 64'(a_irq), 64'd0);
        ir_in = 3'd3; sr = 44'h04_0000_0001;
        vs_uir = 1'b1; vs_udr = 1'b1;
        n = 0;
        while (n < 10 && (a_ta | a_tn) == 4'd0) begin
            tick();
            n++;
            vs_uir = 1'b0;
        end
        chk("coinc take_action", 64'(a_ta), 64'd1);
        chk("coinc ir_q after", 64'(a_irq), 64'd3);
        repeat (2) tick();
        chk("coinc pending", 64'(a_pend), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset pending", 64'(a_pend), 64'd0);
        chk("async reset jdo", 64'(a_jdo), 64'd0);
        for (int i = 0; i < 3; i++) m[i] = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        strb_a = 0; strb_c = 0;
        repeat (8) tick();
        chk("held udr after reset a", 64'(strb_a), 64'd1);
        chk("held udr after reset c", 64'(strb_c), 64'd1);
        vs_udr = 1'b0;
        act_ack = 1'b1;
        tick();
        act_ack = 1'b0;

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) vs_udr = ~vs_udr;
            if ($urandom_range(0, 3) == 0) vs_uir = ~vs_uir;
            ir_in = 3'($urandom);
            r64 = {$urandom, $urandom};
            sr = r64[43:0];
            act_ack = ($urandom_range(0, 3) == 0);
            clear_overrun = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 399) == 0) do_reset();
            tick();
        end
        act_ack = 1'b0; clear_overrun = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
